f_fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the P7 pipeline: owns the fetch PC, issues requests to a fixed one-cycle-latency instruction memory, and buffers fetched instructions in a DEPTH-entry FIFO feeding the D stage. It handles branch/jump redirects, ERET return, and exception-entry redirects with queue flush. It tags address faults with the ADEL exception code instead of fetching.

---
 rtl/f_fetch_queue.sv | 124 ++++++++++++
 tb/tb_f_fetch_queue.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/f_fetch_queue.sv
// rtl/f_fetch_queue.sv - instruction fetch PC, one-cycle imem request and DEPTH-entry fetch FIFO
// Address fault (ADEL) tagging and halt are enabled by defining FETCH_ADDR_CHECK_EN.
module f_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter logic [31:0] ADDR_LO  = 32'h0000_3000,
  parameter logic [31:0] ADDR_HI  = 32'h0000_6ffc,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [4:0]  out_exc,
  input  logic        out_ready
);

  localparam int         PW       = $clog2(DEPTH);
  localparam logic [PW:0] W_DEPTH = (PW+1)'(DEPTH);
  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0]   r_pc;
  logic          r_halted;
  logic          r_inflight;
  logic [31:0]   r_if_pc;
  logic          r_if_fault;
  logic [31:0]   r_fifo_pc    [DEPTH];
  logic [31:0]   r_fifo_instr [DEPTH];
  logic          r_fifo_fault [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_count;

  logic          w_redirect;
  logic [31:0]   w_target;
  logic          w_fault;
  logic [PW:0]   w_occupancy;
  logic          w_slot;
  logic          w_enq;
  logic          w_deq;

  assign w_redirect = exc_req | eret | redirect_valid;
  assign w_target   = exc_req ? EXC_PC : (eret ? epc : redirect_pc);

`ifdef FETCH_ADDR_CHECK_EN
  assign w_fault = (r_pc[1:0] != 2'b00) || (r_pc < ADDR_LO) || (r_pc > ADDR_HI);
`else
  assign w_fault = 1'b0;
`endif

  // The in-flight slot reserves a FIFO entry so its response always has room.
  assign w_occupancy = r_count + {{PW{1'b0}}, r_inflight};
  assign w_slot      = !reset && !w_redirect && !r_halted && (w_occupancy < W_DEPTH);
  assign w_enq       = r_inflight && !w_redirect && !reset;
  assign w_deq       = out_valid && out_ready;

  assign imem_req  = w_slot && !w_fault;
  assign imem_addr = r_pc;

  assign out_valid = (r_count != '0);
  assign out_pc    = out_valid ? r_fifo_pc[r_rd_ptr]    : 32'h0;
  assign out_instr = out_valid ? r_fifo_instr[r_rd_ptr] : 32'h0;
  assign out_exc   = (out_valid && r_fifo_fault[r_rd_ptr]) ? EXC_ADEL : 5'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_halted   <= 1'b0;
      r_inflight <= 1'b0;
      r_if_pc    <= 32'h0;
      r_if_fault <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (w_redirect) begin
      r_pc       <= w_target;
      r_halted   <= 1'b0;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_slot;
      if (w_slot) begin
        r_if_pc    <= r_pc;
        r_if_fault <= w_fault;
        if (w_fault) begin
          r_halted <= 1'b1;
        end else begin
          r_pc <= r_pc + 32'd4;
        end
      end
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_fifo_pc[r_wr_ptr]    <= r_if_pc;
      r_fifo_instr[r_wr_ptr] <= r_if_fault ? 32'h0 : imem_rdata;
      r_fifo_fault[r_wr_ptr] <= r_if_fault;
    end
  end

endmodule

// File: tb/tb_f_fetch_queue.sv
// tb/tb_f_fetch_queue.sv - scoreboard bench for f_fetch_queue with a one-cycle imem model
module tb_f_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [4:0]  out_exc;
  logic        out_ready;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
  } entry_t;

  entry_t sb_q[$];
  bit     sb_on = 1'b0;
  int     n_checks = 0;
  int     n_pass = 0;
  int     n_pops = 0;

  f_fetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .exc_req        (exc_req),
    .eret           (eret),
    .epc            (epc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_exc        (out_exc),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5a5a_0f0f;
  endfunction

  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back('{pc: start + 32'(4 * i), instr: mem_word(start + 32'(4 * i)), exc: 5'd0});
    end
  endtask

  always @(negedge clk) begin
    if (sb_on && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_entry", {31'd0, out_valid}, 32'd0);
      end else begin
        entry_t e;
        e = sb_q.pop_front();
        check_eq("out_pc", out_pc, e.pc);
        check_eq("out_instr", out_instr, e.instr);
        check_eq("out_exc", {27'd0, out_exc}, {27'd0, e.exc});
        n_pops++;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    sb_q.delete();
    push_run(32'h3000, 40);
  endtask

  task automatic redirect(input logic x_i, input logic e_i, input logic r_i,
                          input logic [31:0] epc_i, input logic [31:0] rpc_i,
                          input logic [31:0] exp_pc, input bit fault);
    exc_req = x_i;
    eret = e_i;
    epc = epc_i;
    redirect_valid = r_i;
    redirect_pc = rpc_i;
    @(negedge clk);
    check_eq("redir_cycle_req", {31'd0, imem_req}, 32'd0);
    tick();
    exc_req = 1'b0;
    eret = 1'b0;
    redirect_valid = 1'b0;
    sb_q.delete();
    if (fault) sb_q.push_back('{pc: exp_pc, instr: 32'h0, exc: 5'd4});
    else push_run(exp_pc, 40);
    @(negedge clk);
    check_eq("redir_t1_addr", imem_addr, exp_pc);
    check_eq("redir_t1_req", {31'd0, imem_req}, {31'd0, !fault});
    check_eq("redir_t1_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check_eq("redir_t2_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check_eq("redir_t3_valid", {31'd0, out_valid}, 32'd1);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    exc_req = 1'b0;
    eret = 1'b0;
    epc = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b1;

    // Reset values and streaming fetch from RESET_PC.
    tick();
    tick();
    @(negedge clk);
    check_eq("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_imem_addr", imem_addr, 32'h3000);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_pc", out_pc, 32'h0);
    check_eq("rst_out_instr", out_instr, 32'h0);
    check_eq("rst_out_exc", {27'd0, out_exc}, 32'd0);
    tick();
    reset = 1'b0;
    sb_q.delete();
    push_run(32'h3000, 40);
    sb_on = 1'b1;
    n_pops = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("stream_req", {31'd0, imem_req}, 32'd1);
      check_eq("stream_addr", imem_addr, 32'h3000 + 32'(4 * i));
      if (i < 2) check_eq("stream_fill_valid", {31'd0, out_valid}, 32'd0);
    end
    tick();
    check_eq("stream_pops", 32'(n_pops), 32'd6);

    // Backpressure: exactly DEPTH requests, then resume without loss.
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("full_req", {31'd0, imem_req}, {31'd0, (i < 4)});
      if (i < 4) check_eq("full_addr", imem_addr, 32'h3000 + 32'(4 * i));
    end
    tick();
    out_ready = 1'b1;
    n_pops = 0;
    @(negedge clk);
    check_eq("resume_r0_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    check_eq("resume_r1_req", {31'd0, imem_req}, 32'd1);
    check_eq("resume_r1_addr", imem_addr, 32'h3010);
    repeat (4) @(negedge clk);
    tick();
    check_eq("resume_pops", 32'(n_pops), 32'd6);

    // Branch redirect with a request in flight.
    do_reset();
    repeat (5) tick();
    redirect(1'b0, 1'b0, 1'b1, 32'h0, 32'h3400, 32'h3400, 1'b0);
    repeat (3) tick();

    // Priority: eret over branch, exception over both.
    redirect(1'b0, 1'b1, 1'b1, 32'h3100, 32'h3200, 32'h3100, 1'b0);
    repeat (3) tick();
    redirect(1'b1, 1'b1, 1'b1, 32'h3100, 32'h3200, 32'h4180, 1'b0);
    repeat (3) tick();

    // Misaligned target.
`ifdef FETCH_ADDR_CHECK_EN
    redirect(1'b0, 1'b0, 1'b1, 32'h0, 32'h3002, 32'h3002, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("halt_req", {31'd0, imem_req}, 32'd0);
      check_eq("halt_valid", {31'd0, out_valid}, 32'd0);
    end
    tick();
    redirect(1'b0, 1'b0, 1'b1, 32'h0, 32'h4180, 32'h4180, 1'b0);
`else
    redirect(1'b0, 1'b0, 1'b1, 32'h0, 32'h3002, 32'h3002, 1'b0);
    n_pops = 0;
`endif
    repeat (4) tick();
`ifndef FETCH_ADDR_CHECK_EN
    check_eq("nocheck_pops", 32'(n_pops), 32'd4);
`endif
    sb_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
